cc_window_qualifier: RTL
========================

// Module: cc_window_qualifier
// PURPOSE
//  Parametrised, registered window comparator. Flags when data_InBUS lies in a programmable [low,high]
//  window for QUAL_CYCLES consecutive valid samples; also reports below/above and entry/exit pulses.
//  Successor of the fixed "count == 9" terminal-count detector. Sits after BCD/score/position counters.
//  Defaults of low = high = 9 reproduce the terminal-9 detect, with one cycle of latency.
// PARAMETERS
//  DATAWIDTH     4   width of data and bounds (>=2)
//  LOW_DEFAULT   9   low bound after reset
//  HIGH_DEFAULT  9   high bound after reset
//  QUAL_CYCLES   1   consecutive in-window valid samples required (>=1)
// PORTS
//  CC_WINQUAL_CLOCK_50       in   1          system clock, rising edge
//  CC_WINQUAL_RESET_InLow    in   1          asynchronous, active-low reset
//  CC_WINQUAL_valid_In       in   1          sample enable for data_InBUS
//  CC_WINQUAL_data_InBUS     in   DATAWIDTH  unsigned value under test
//  CC_WINQUAL_load_In        in   1          load bounds strobe
//  CC_WINQUAL_low_InBUS      in   DATAWIDTH  new low bound (inclusive)
//  CC_WINQUAL_high_InBUS     in   DATAWIDTH  new high bound (inclusive)
//  CC_WINQUAL_clear_In       in   1          clear sticky hit (STICKY build only)
//  CC_WINQUAL_inside_OutLow  out  1          0 = qualified in-window
//  CC_WINQUAL_below_Out      out  1          last valid sample < low
//  CC_WINQUAL_above_Out      out  1          last valid sample > high
//  CC_WINQUAL_enter_Out      out  1          1-cycle pulse on qualification
//  CC_WINQUAL_exit_Out       out  1          1-cycle pulse on de-qualification
//  CC_WINQUAL_error_Out      out  1          bounds invalid (low > high)
//  CC_WINQUAL_hit_OutLow     out  1          0 = window hit since last clear (sticky)
// BEHAVIOUR
//  Reset (async assert, sync release): bounds = defaults; state OUTSIDE; count 0.
//   Outputs on reset: inside_OutLow = 1, hit_OutLow = 1; below, above, enter, exit and error = 0.
//  Compare: unsigned, full DATAWIDTH. raw_in = (low<=d)&&(d<=high)&&!error.
//  Latency: all outputs registered; they update on the edge that samples valid_In=1.
//  valid_In=0: state, count, below and above hold; enter and exit are 0.
//  Count: width $clog2(QUAL_CYCLES+1), saturates at QUAL_CYCLES, never wraps.
//  FSM (advances on valid samples only):
//   OUTSIDE: raw_in and QUAL_CYCLES==1 -> INSIDE, enter=1.
//            raw_in otherwise -> QUALIFYING, count=1.
//   QUALIFYING: !raw_in -> OUTSIDE, count=0, no exit pulse.
//               raw_in and count+1==QUAL_CYCLES -> INSIDE, enter=1.
//   INSIDE: !raw_in -> OUTSIDE, count=0, exit=1, inside_OutLow=1 on the same edge.
//  inside_OutLow = 0 exactly while the state is INSIDE.
//  below = d<low; above = d>high; both stay valid even when error=1.
//  Load: bounds update at the load edge; error_Out=(new low>new high) on the same edge.
//   A sample taken in the load cycle is compared against the OLD bounds for below/above.
//   The FSM is forced to OUTSIDE with count=0; exit=1 if the previous state was INSIDE.
//   Load has priority over a simultaneous qualification, so no enter pulse is issued.
//  Boundaries: d==low and d==high are inside. Window low==high gives an exact-match detect.
//   Full-scale window 0..2^W-1 is always raw_in.
//  Reset mid-qualification abandons the count immediately; no pulse is produced.
// CONFIGURATION
//  WINQUAL_STICKY_EN defined: hit_OutLow is set to 0 on the edge where enter=1.
//   It holds until clear_In=1 at an edge, which sets it to 1.
//   If clear and enter occur on the same edge, enter wins and hit_OutLow=0.
//  WINQUAL_STICKY_EN undefined: hit_OutLow is tied to 1'b1; clear_In is ignored and no sticky flop exists.
// TESTING
//  T1 defaults, QUAL=1: valid data 8,9,10 -> inside_OutLow 1,0,1; enter at 9, exit at 10; above at 10.
//  T2 QUAL=3, window 3..5: data 4,4,2,4,4,4 -> count resets at 2; inside_OutLow=0 only after the 6th sample.
//  T3 load low=7, high=2 -> error=1; data 5 -> inside_OutLow stays 1; below=1, above=1.
//  T4 INSIDE, then load_In with valid data -> exit pulse, state OUTSIDE, no enter on that edge.
//  T5 valid_In=0 for 5 cycles mid-QUALIFYING -> count held; next valid in-window sample completes qualification.
//  T6 STICKY: enter then exit -> hit_OutLow stays 0; clear_In -> 1; clear together with enter -> 0.
//     Non-STICKY build: hit_OutLow stays 1 throughout.
//  All tests: assert RESET_InLow mid-sequence -> outputs go to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/cc_window_qualifier.sv
// Registered window comparator: qualifies a sample stream against a programmable [low,high] window.
// Optional sticky hit flag enabled by defining WINQUAL_STICKY_EN.
module cc_window_qualifier #(
   parameter int DATAWIDTH    = 4,
   parameter int LOW_DEFAULT  = 9,
   parameter int HIGH_DEFAULT = 9,
   parameter int QUAL_CYCLES  = 1
) (
   input  logic                 CC_WINQUAL_CLOCK_50,
   input  logic                 CC_WINQUAL_RESET_InLow,
   input  logic                 CC_WINQUAL_valid_In,
   input  logic [DATAWIDTH-1:0] CC_WINQUAL_data_InBUS,
   input  logic                 CC_WINQUAL_load_In,
   input  logic [DATAWIDTH-1:0] CC_WINQUAL_low_InBUS,
   input  logic [DATAWIDTH-1:0] CC_WINQUAL_high_InBUS,
   input  logic                 CC_WINQUAL_clear_In,
   output logic                 CC_WINQUAL_inside_OutLow,
   output logic                 CC_WINQUAL_below_Out,
   output logic                 CC_WINQUAL_above_Out,
   output logic                 CC_WINQUAL_enter_Out,
   output logic                 CC_WINQUAL_exit_Out,
   output logic                 CC_WINQUAL_error_Out,
   output logic                 CC_WINQUAL_hit_OutLow
);

   localparam int CW = $clog2(QUAL_CYCLES + 1);
   localparam logic [CW-1:0] QUAL_C = CW'(QUAL_CYCLES);

   typedef enum logic [1:0] {
      OUTSIDE    = 2'd0,
      QUALIFYING = 2'd1,
      INSIDE     = 2'd2
   } stateT;

   stateT                state;
   logic [CW-1:0]        count;
   logic [DATAWIDTH-1:0] lowBound;
   logic [DATAWIDTH-1:0] highBound;
   logic                 errorReg;
   logic                 insideLowReg;
   logic                 belowReg;
   logic                 aboveReg;
   logic                 enterReg;
   logic                 exitReg;
   logic                 rawIn;
   logic                 qualifyNow;

   // An inverted window (low > high) never counts as in-window
   assign rawIn = (lowBound <= CC_WINQUAL_data_InBUS) &&
                  (CC_WINQUAL_data_InBUS <= highBound) && !errorReg;

   // Qualification completes on this edge; a simultaneous load suppresses it
   assign qualifyNow = CC_WINQUAL_valid_In && !CC_WINQUAL_load_In && rawIn &&
                       (((state == OUTSIDE) && (QUAL_CYCLES == 1)) ||
                        ((state == QUALIFYING) && ((count + CW'(1)) == QUAL_C)));

   // Bounds, FSM and all status flags share one register stage
   always_ff @(posedge CC_WINQUAL_CLOCK_50 or negedge CC_WINQUAL_RESET_InLow) begin
      if (!CC_WINQUAL_RESET_InLow) begin
         state        <= OUTSIDE;
         count        <= '0;
         lowBound     <= DATAWIDTH'(LOW_DEFAULT);
         highBound    <= DATAWIDTH'(HIGH_DEFAULT);
         errorReg     <= 1'b0;
         insideLowReg <= 1'b1;
         belowReg     <= 1'b0;
         aboveReg     <= 1'b0;
         enterReg     <= 1'b0;
         exitReg      <= 1'b0;
      end else begin
         enterReg <= 1'b0;
         exitReg  <= 1'b0;
         if (CC_WINQUAL_valid_In) begin
            belowReg <= CC_WINQUAL_data_InBUS < lowBound;
            aboveReg <= CC_WINQUAL_data_InBUS > highBound;
         end
         if (CC_WINQUAL_load_In) begin
            lowBound     <= CC_WINQUAL_low_InBUS;
            highBound    <= CC_WINQUAL_high_InBUS;
            errorReg     <= CC_WINQUAL_low_InBUS > CC_WINQUAL_high_InBUS;
            state        <= OUTSIDE;
            count        <= '0;
            insideLowReg <= 1'b1;
            exitReg      <= (state == INSIDE);
         end else if (CC_WINQUAL_valid_In) begin
            if (qualifyNow) begin
               state        <= INSIDE;
               count        <= QUAL_C;
               insideLowReg <= 1'b0;
               enterReg     <= 1'b1;
            end else begin
               case (state)
                  OUTSIDE: begin
                     if (rawIn) begin
                        state <= QUALIFYING;
                        count <= CW'(1);
                     end
                  end
                  QUALIFYING: begin
                     if (rawIn) begin
                        count <= count + CW'(1);
                     end else begin
                        state <= OUTSIDE;
                        count <= '0;
                     end
                  end
                  INSIDE: begin
                     if (!rawIn) begin
                        state        <= OUTSIDE;
                        count        <= '0;
                        insideLowReg <= 1'b1;
                        exitReg      <= 1'b1;
                     end
                  end
                  default: begin
                     state        <= OUTSIDE;
                     count        <= '0;
                     insideLowReg <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

   assign CC_WINQUAL_inside_OutLow = insideLowReg;
   assign CC_WINQUAL_below_Out     = belowReg;
   assign CC_WINQUAL_above_Out     = aboveReg;
   assign CC_WINQUAL_enter_Out     = enterReg;
   assign CC_WINQUAL_exit_Out      = exitReg;
   assign CC_WINQUAL_error_Out     = errorReg;

`ifdef WINQUAL_STICKY_EN
   logic hitLowReg;

   // Enter outranks clear so a hit landing on the clear edge is not lost
   always_ff @(posedge CC_WINQUAL_CLOCK_50 or negedge CC_WINQUAL_RESET_InLow) begin
      if (!CC_WINQUAL_RESET_InLow) begin
         hitLowReg <= 1'b1;
      end else if (qualifyNow) begin
         hitLowReg <= 1'b0;
      end else if (CC_WINQUAL_clear_In) begin
         hitLowReg <= 1'b1;
      end
   end

   assign CC_WINQUAL_hit_OutLow = hitLowReg;
`else
   logic unusedClear;
   assign unusedClear           = CC_WINQUAL_clear_In;
   assign CC_WINQUAL_hit_OutLow = 1'b1;
`endif

endmodule
